// File: rtl/multi_dataflow_package.sv
// Shared constants and types for the multi_dataflow TCDM arbiter.
package multi_dataflow_package;

    localparam int MDF_ARB_NR_DEFAULT    = 4;
    localparam int MDF_ARB_DEPTH_DEFAULT = 4;

    typedef logic [$clog2(MDF_ARB_NR_DEFAULT)-1:0] mdf_arb_idx_t;

endpackage

// File: rtl/multi_dataflow_tcdm_arb_tagfifo.sv
// In-order FIFO of granted requester indices, used to route TCDM responses back
// to the requester that issued the matching request.
module multi_dataflow_tcdm_arb_tagfifo
    import multi_dataflow_package::*;
#(
    parameter int DEPTH = MDF_ARB_DEPTH_DEFAULT,
    parameter int IDX_W = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [IDX_W-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [IDX_W-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W:0]   wptr;
    logic [PTR_W:0]   rptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr[PTR_W-1:0]] <= din;
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]) && (wptr[PTR_W] != rptr[PTR_W]);
    assign head  = mem[rptr[PTR_W-1:0]];
    assign count = CNT_W'(wptr - rptr);

endmodule

// File: rtl/multi_dataflow_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among NR requesters, with a
// tag FIFO that steers in-order responses back to their issuers.
module multi_dataflow_tcdm_arbiter
    import multi_dataflow_package::*;
#(
    parameter int NR    = MDF_ARB_NR_DEFAULT,
    parameter int DEPTH = MDF_ARB_DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NR-1:0]              in_req,
    output logic [NR-1:0]              in_gnt,
    input  logic [NR*32-1:0]           in_add,
    input  logic [NR-1:0]              in_wen,
    input  logic [NR*4-1:0]            in_be,
    input  logic [NR*32-1:0]           in_data,
    output logic [NR*32-1:0]           in_r_data,
    output logic [NR-1:0]              in_r_valid,
    output logic                       tcdm_req,
    input  logic                       tcdm_gnt,
    output logic [31:0]                tcdm_add,
    output logic                       tcdm_wen,
    output logic [3:0]                 tcdm_be,
    output logic [31:0]                tcdm_data,
    input  logic [31:0]                tcdm_r_data,
    input  logic                       tcdm_r_valid,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       err_o
);

    localparam int IDX_W = $clog2(NR);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [IDX_W-1:0] rr_ptr;
    logic             lock;
    logic [IDX_W-1:0] lock_idx;
    logic             err;

    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   scan;
    logic [IDX_W:0]   win_inc;
    logic [IDX_W-1:0] rr_next;
    logic             req_ok;
    logic             handshake;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;

    logic [31:0] add_arr  [NR];
    logic [31:0] data_arr [NR];
    logic [3:0]  be_arr   [NR];

    for (genvar g = 0; g < NR; g++) begin : g_unpack
        assign add_arr[g]  = in_add[g*32 +: 32];
        assign data_arr[g] = in_data[g*32 +: 32];
        assign be_arr[g]   = in_be[g*4 +: 4];
    end

    // A locked winner is kept even if higher-priority requesters show up.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = '0;
        if (lock) begin
            win_vld = in_req[lock_idx];
            win_idx = lock_idx;
        end else begin
            for (int i = 0; i < NR; i++) begin
                scan = {1'b0, rr_ptr} + (IDX_W+1)'(i);
                if (scan >= (IDX_W+1)'(NR)) scan = scan - (IDX_W+1)'(NR);
                if (!win_vld && in_req[scan[IDX_W-1:0]]) begin
                    win_vld = 1'b1;
                    win_idx = scan[IDX_W-1:0];
                end
            end
        end
    end

    assign win_inc   = {1'b0, win_idx} + 1'b1;
    assign rr_next   = (win_inc == (IDX_W+1)'(NR)) ? '0 : win_inc[IDX_W-1:0];
    assign req_ok    = win_vld && !fifo_full && !rst_i;
    assign handshake = req_ok && tcdm_gnt;
    assign pop       = tcdm_r_valid && !fifo_empty && !rst_i;

    assign tcdm_req  = req_ok;
    assign tcdm_add  = (win_vld && !rst_i) ? add_arr[win_idx]  : '0;
    assign tcdm_wen  = (win_vld && !rst_i) ? in_wen[win_idx]   : 1'b0;
    assign tcdm_be   = (win_vld && !rst_i) ? be_arr[win_idx]   : '0;
    assign tcdm_data = (win_vld && !rst_i) ? data_arr[win_idx] : '0;

    always_comb begin
        in_gnt     = '0;
        in_r_valid = '0;
        if (handshake) in_gnt[win_idx]       = 1'b1;
        if (pop)       in_r_valid[fifo_head] = 1'b1;
    end

    assign in_r_data     = {NR{tcdm_r_data}};
    assign outstanding_o = rst_i ? '0 : fifo_count;
    assign err_o         = err && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            err      <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr <= rr_next;
                lock   <= 1'b0;
            end else if (req_ok) begin
                lock     <= 1'b1;
                lock_idx <= win_idx;
            end else if (lock && !in_req[lock_idx]) begin
                lock <= 1'b0;
            end
            if (tcdm_r_valid && fifo_empty) err <= 1'b1;
        end
    end

    multi_dataflow_tcdm_arb_tagfifo #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) i_tagfifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (handshake),
        .pop   (pop),
        .din   (win_idx),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head),
        .count (fifo_count)
    );

endmodule

// File: doc/multi_dataflow_tcdm_arbiter.md
# multi_dataflow_tcdm_arbiter

Round-robin arbiter that shares one TCDM master port among `NR` requesters inside the multi_dataflow HWPE, for example streamer source/sink channels that outnumber the `MP` ports exposed by the top wrapper. It forwards the winning request to the TCDM port and records the winner's index in an in-order tag FIFO. It routes each returning `r_valid` back to the requester that issued the request. It sits between the streamers and one lane of the top-level `tcdm_*` bundle.

## Interface
- `NR`, 4: number of requesters; 2..16.
- `DEPTH`, 4: maximum outstanding (granted, unanswered) transactions; power of two, ≥2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `in_req`  in  NR  per-requester request.
- `in_gnt`  out  NR  per-requester grant.
- `in_add`  in  NR×32  per-requester address.
- `in_wen`  in  NR  per-requester write-enable; 1 = read, HWPE convention.
- `in_be`  in  NR×4  per-requester byte enables.
- `in_data`  in  NR×32  per-requester write data.
- `in_r_data`  out  NR×32  response data, the same value broadcast to all lanes.
- `in_r_valid`  out  NR  per-requester response valid.
- `tcdm_req`  out  1  downstream request.
- `tcdm_gnt`  in  1  downstream grant.
- `tcdm_add`  out  32  downstream address.
- `tcdm_wen`  out  1  downstream write-enable.
- `tcdm_be`  out  4  downstream byte enables.
- `tcdm_data`  out  32  downstream write data.
- `tcdm_r_data`  in  32  downstream response data.
- `tcdm_r_valid`  in  1  downstream response valid.
- `outstanding_o`  out  $clog2(DEPTH+1)  current tag-FIFO occupancy.
- `err_o`  out  1  sticky flag, set when `tcdm_r_valid` arrives while the FIFO is empty.

## Operation
- State:
  - `rr_ptr` (index): highest-priority requester.
  - `lock` (1 bit) and `lock_idx` (index): hold a pending arbitration decision.
  - Tag FIFO of indices: `DEPTH` entries, read/write pointers with wrap bit.
  - `err` (1 bit).
- Arbitration, combinational:
  - When `lock` = 0, the winner is the first requester with `in_req` set, scanning `rr_ptr`, `rr_ptr+1`, … modulo `NR`.
  - When `lock` = 1, the winner is `lock_idx`, regardless of other requests.
- Forwarding:
  - `tcdm_req` = winner valid AND FIFO not full.
  - `tcdm_add`, `tcdm_wen`, `tcdm_be` and `tcdm_data` are muxed from the winner. They are 0 when there is no winner.
  - `in_gnt[w]` = `tcdm_gnt` AND `tcdm_req`, for the winner only. All other grants are 0.
- Handshake completes when `tcdm_req` AND `tcdm_gnt`. On that cycle:
  - Push the winner index into the FIFO.
  - Set `rr_ptr` ← winner+1 mod `NR`.
  - Clear `lock`.
- Request not granted (`tcdm_req`=1, `tcdm_gnt`=0):
  - Set `lock` ← 1 and `lock_idx` ← winner.
  - The address stays stable, so requesters are never re-arbitrated mid-handshake.
- Response handling:
  - On `tcdm_r_valid`, pop the FIFO head `h`.
  - Drive `in_r_valid[h]` = 1; all other `in_r_valid` are 0.
  - `in_r_data` = `tcdm_r_data` on every lane.
- Boundary conditions:
  - **FIFO full:** `tcdm_req` = 0 and every `in_gnt` = 0. `lock` holds its value.
  - **Push and pop in the same cycle:** occupancy is unchanged. With a full FIFO the pop frees a slot only on the next cycle, so no push happens that cycle.
  - **`tcdm_r_valid` with an empty FIFO:** no `in_r_valid` is raised and `err` is set. `err` clears only on reset.
  - **Locked winner drops `in_req`:** this is illegal under the protocol. The arbiter clears `lock` on that cycle and drives no request from that requester.
  - **Pointer wrap:** index arithmetic is modulo `NR`. FIFO pointers are `$clog2(DEPTH)` bits plus a wrap bit; full = indices equal and wrap bits differ.
- Reset mid-operation:
  - Empties the FIFO, sets `rr_ptr` = 0, clears `lock` and clears `err`.
  - Responses to transactions already in flight are dropped and set `err` once reset is released. Integration must quiesce the TCDM before asserting reset.

## Timing
- Request path is zero-latency combinational, from `in_*` and `tcdm_gnt` to `tcdm_*` and `in_gnt`.
- Response path is zero-latency combinational, from `tcdm_r_valid` to `in_r_valid[h]`. TCDM responds at least 1 cycle after grant, in order.
- Throughput is one grant per cycle while the FIFO is not full.
- While `rst_i` = 1:
  - `tcdm_req`, `in_gnt` and `in_r_valid` are forced to 0.
  - `outstanding_o` = 0 and `err_o` = 0.
  - `tcdm_add`, `tcdm_wen`, `tcdm_be` and `tcdm_data` are 0.
- Fairness: a requester that is continuously requesting wins within `NR` grants.

## Structure
- Package `multi_dataflow_package` gains:
  - `MDF_ARB_NR_DEFAULT` = 4.
  - `MDF_ARB_DEPTH_DEFAULT` = 4.
  - Typedef `mdf_arb_idx_t` = `logic [$clog2(MDF_ARB_NR_DEFAULT)-1:0]`.
- One sub-module, `multi_dataflow_tcdm_arb_tagfifo`:
  - Parameters: `DEPTH` and index width.
  - Ports: push/pop, `full`/`empty`, head output, occupancy, synchronous active-high reset.
  - Everything else stays in the top.

## Test plan
- **Round-robin:** `NR`=4; all four `in_req` held high, `tcdm_gnt`=1. Grants go 0,1,2,3,0. `outstanding_o` reaches 2 with the responder at fixed 2-cycle latency.
- **Lock:** requests from 1 and 3 with `rr_ptr`=2; `tcdm_gnt`=0 for 3 cycles, then 1. `tcdm_add` stays equal to `in_add[3]` throughout, `in_gnt[3]` pulses once, then `rr_ptr`=0.
- **FIFO full:** `DEPTH`=4, responder stalled for 6 cycles. After 4 grants `tcdm_req`=0 and `outstanding_o`=4. The first `r_valid` goes to requester 0, and grants resume the next cycle.
- **Response routing:** interleaved reads from 2 and 0 with data 0xA5A5_0002 then 0x0000_0F00. `in_r_valid[2]` then `in_r_valid[0]`, with the matching `in_r_data`.
- **Error and reset:** spurious `tcdm_r_valid` with an empty FIFO sets `err_o`=1, and it stays 1. Asserting `rst_i` for one cycle mid-burst gives `err_o`=0, `outstanding_o`=0 and grants restarting at requester 0.
